// File: rtl/jam_pkg.sv
// Shared definitions for the jam-mode sequencer.
//   jam_state_e    : controller state encoding
//   *_DEF          : default parameter values for jam_sched_ctrl
package jam_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } jam_state_e;

  localparam int CNT_W_DEF        = 8;
  localparam int ENTRY_DLY_DEF    = 4;
  localparam int EXIT_DLY_DEF     = 4;
  localparam int GREEN_CYCLES_DEF = 20;

endpackage

// File: rtl/jam_stable_cnt.sv
// Consecutive-cycle qualifier counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over counting)
//   qual       : qualifier; a low sample restarts the count
//   hit        : combinational; this edge's increment reaches LIMIT
module jam_stable_cnt #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic qual,
  output logic hit
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Saturate so a qualifier held past LIMIT never wraps back to a match.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign hit     = qual && !clr && (cnt_inc == CNT_W'(LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (clr || !qual) cnt <= '0;
    else                   cnt <= cnt_inc;
  end

endmodule

// File: rtl/jam_sched_ctrl.sv
// Jam-mode sequencer driving the jam-operation unit.
//   clk, rst_n        : clock, async active-low reset
//   jam_sensor_0..3   : per-road jam flags (already synchronous)
//   mode_en           : jam mode permitted; low forces IDLE
//   jam_op_en         : jam mode active
//   jam_start         : one-cycle pulse on entry
//   jam_rotation      : one-cycle pulse every GREEN_CYCLES in RUN
//   rot_cnt           : rotations since last start, saturating
module jam_sched_ctrl
  import jam_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int ENTRY_DLY    = ENTRY_DLY_DEF,
  parameter int EXIT_DLY     = EXIT_DLY_DEF,
  parameter int GREEN_CYCLES = GREEN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jam_sensor_0,
  input  logic             jam_sensor_1,
  input  logic             jam_sensor_2,
  input  logic             jam_sensor_3,
  input  logic             mode_en,
  output logic             jam_op_en,
  output logic             jam_start,
  output logic             jam_rotation,
  output logic [CNT_W-1:0] rot_cnt
);

  jam_state_e       state;
  logic [CNT_W-1:0] green_cnt;
  logic [CNT_W-1:0] green_inc;
  logic             any_jam;
  logic             entry_clr, entry_hit;
  logic             exit_clr, exit_hit;
  logic             rot_due;

  assign any_jam = jam_sensor_0 | jam_sensor_1 | jam_sensor_2 | jam_sensor_3;

  // Entry qualification only runs while idle/arming; exit only in RUN.
  assign entry_clr = !mode_en || (state == START) || (state == RUN);
  assign exit_clr  = !mode_en || (state != RUN);

  jam_stable_cnt #(.CNT_W(CNT_W), .LIMIT(ENTRY_DLY)) u_entry (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (entry_clr),
    .qual (any_jam),
    .hit  (entry_hit)
  );

  jam_stable_cnt #(.CNT_W(CNT_W), .LIMIT(EXIT_DLY)) u_exit (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (exit_clr),
    .qual (!any_jam),
    .hit  (exit_hit)
  );

  // green_cnt holds (cycles since the start pulse) mod GREEN_CYCLES, so it
  // is 0 in the start cycle and in every rotation cycle.
  assign green_inc = green_cnt + 1'b1;
  assign rot_due   = (green_inc == CNT_W'(GREEN_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      jam_op_en    <= 1'b0;
      jam_start    <= 1'b0;
      jam_rotation <= 1'b0;
      green_cnt    <= '0;
      rot_cnt      <= '0;
    end else if (!mode_en) begin
      // rot_cnt deliberately holds across a forced exit.
      state        <= IDLE;
      jam_op_en    <= 1'b0;
      jam_start    <= 1'b0;
      jam_rotation <= 1'b0;
      green_cnt    <= '0;
    end else begin
      jam_start    <= 1'b0;
      jam_rotation <= 1'b0;
      case (state)
        IDLE, ARM: begin
          if (entry_hit) begin
            state     <= START;
            jam_op_en <= 1'b1;
            jam_start <= 1'b1;
            green_cnt <= '0;
            rot_cnt   <= '0;
          end else begin
            state     <= any_jam ? ARM : IDLE;
            jam_op_en <= 1'b0;
          end
        end
        START, RUN: begin
          // Exit beats a coincident rotation: no pulse on the exit edge.
          if (state == RUN && exit_hit) begin
            state     <= IDLE;
            jam_op_en <= 1'b0;
            green_cnt <= '0;
          end else begin
            state     <= RUN;
            jam_op_en <= 1'b1;
            if (rot_due) begin
              jam_rotation <= 1'b1;
              green_cnt    <= '0;
              if (rot_cnt != '1) rot_cnt <= rot_cnt + 1'b1;
            end else begin
              green_cnt <= green_inc;
            end
          end
        end
        default: begin
          state     <= IDLE;
          jam_op_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jam_sched_ctrl.sv
module tb_jam_sched_ctrl;

  localparam int CNT_W = 8;
  localparam int ENTRY = 4;
  localparam int EXITD = 4;
  localparam int GREEN = 20;
  localparam int RMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode_en = 1'b0;
  logic jam_sensor_0 = 1'b0, jam_sensor_1 = 1'b0, jam_sensor_2 = 1'b0, jam_sensor_3 = 1'b0;
  logic jam_op_en, jam_start, jam_rotation;
  logic [CNT_W-1:0] rot_cnt;

  always #5 clk = ~clk;

  jam_sched_ctrl #(.CNT_W(CNT_W), .ENTRY_DLY(ENTRY), .EXIT_DLY(EXITD), .GREEN_CYCLES(GREEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .jam_sensor_0(jam_sensor_0), .jam_sensor_1(jam_sensor_1),
    .jam_sensor_2(jam_sensor_2), .jam_sensor_3(jam_sensor_3),
    .mode_en(mode_en),
    .jam_op_en(jam_op_en), .jam_start(jam_start), .jam_rotation(jam_rotation),
    .rot_cnt(rot_cnt)
  );

  typedef struct packed {
    logic             op;
    logic             st;
    logic             rot;
    logic [CNT_W-1:0] rc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: jam mode as "active since age 0", with rotations on
  // every age that is a multiple of GREEN and streak counters for entry/exit.
  int m_active, m_age, m_streak, m_quiet, m_rot, m_rotc;

  task automatic model_reset();
    m_active = 0; m_age = 0; m_streak = 0; m_quiet = 0; m_rot = 0; m_rotc = 0;
  endtask

  task automatic model_edge(input logic r, input logic m, input logic any);
    if (!r) begin
      model_reset();
    end else if (!m) begin
      m_active = 0; m_streak = 0; m_quiet = 0; m_rot = 0;
    end else if (m_active == 0) begin
      m_rot = 0;
      m_streak = any ? m_streak + 1 : 0;
      if (m_streak >= ENTRY) begin
        m_active = 1; m_age = 0; m_rotc = 0; m_streak = 0; m_quiet = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1; m_quiet = 0; m_rot = 0;
    end else begin
      m_quiet = any ? 0 : m_quiet + 1;
      if (m_quiet >= EXITD) begin
        m_active = 0; m_rot = 0; m_quiet = 0;
      end else begin
        m_age++;
        m_rot = (m_age % GREEN == 0);
        if (m_rot != 0 && m_rotc < RMAX) m_rotc++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.op  = (m_active != 0);
    e.st  = (m_active != 0) && (m_age == 0);
    e.rot = (m_rot != 0);
    e.rc  = CNT_W'(m_rotc);
    return e;
  endfunction

  task automatic step(input logic r, input logic m, input logic [3:0] s);
    @(negedge clk);
    rst_n = r; mode_en = m;
    {jam_sensor_3, jam_sensor_2, jam_sensor_1, jam_sensor_0} = s;
    @(posedge clk);
    model_edge(r, m, |s);
    q.push_back(model_out());
  endtask

  task automatic steps(input int n, input logic [3:0] s);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, s);
  endtask

  // Monitor: the DUT presents a new output word after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({jam_op_en, jam_start, jam_rotation, rot_cnt} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got op=%b st=%b rot=%b rc=%0d want op=%b st=%b rot=%b rc=%0d",
                   $time, jam_op_en, jam_start, jam_rotation, rot_cnt, e.op, e.st, e.rot, e.rc);
        end
        checks++;
        if ((jam_start && jam_rotation) || ((jam_start || jam_rotation) && !jam_op_en)) begin
          errors++;
          $display("FAIL pulse_invariant t=%0t got op=%b st=%b rot=%b want no overlap and op high",
                   $time, jam_op_en, jam_start, jam_rotation);
        end
      end
    end
  end

  initial begin
    logic [3:0] s;
    int p;
    model_reset();

    // Reset with random sensors, then release with sensors clear.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'($urandom_range(15)));
    steps(3, 4'b0000);

    // Entry on road 2, rotations over 65 cycles, then exit attempts.
    steps(ENTRY, 4'b0100);
    steps(65, 4'b0100);
    steps(3, 4'b0000);
    steps(1, 4'b0001);
    steps(EXITD, 4'b0000);
    steps(2, 4'b0000);

    // Glitch rejection, then a full burst; exit lands on T+40.
    steps(3, 4'b0010);
    steps(1, 4'b0000);
    steps(ENTRY, 4'b0010);
    steps(36, 4'b0010);
    steps(EXITD, 4'b0000);
    steps(3, 4'b0000);

    // mode_en override mid-RUN; rot_cnt holds; re-entry afterwards.
    steps(ENTRY + 25, 4'b1000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1000);
    steps(ENTRY + 3, 4'b1000);

    // Async reset mid-RUN: outputs drop without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({jam_op_en, jam_start, jam_rotation, rot_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got op=%b st=%b rot=%b rc=%0d want all 0",
               jam_op_en, jam_start, jam_rotation, rot_cnt);
    end
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'b1111);
    steps(2, 4'b0000);

    // Randomized phases with varying jam density and occasional mode drops.
    for (int b = 0; b < 60; b++) begin
      case ($urandom_range(3))
        0: p = 10;
        1: p = 50;
        2: p = 90;
        default: p = 100;
      endcase
      for (int i = 0; i < 50; i++) begin
        s = ($urandom_range(99) < p) ? 4'($urandom_range(15, 1)) : 4'b0000;
        step(1'b1, ($urandom_range(99) >= 2), s);
      end
    end

    // Long jam to drive rot_cnt into saturation, then exit.
    steps(2, 4'b0000);
    steps(ENTRY + GREEN * (RMAX + 3), 4'b0101);
    steps(EXITD + 2, 4'b0000);

    // Drain the scoreboard with a bounded wait.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
